// File: rtl/dcache_pkg.sv
// Shared geometry and state encoding for the data cache.
package dcache_pkg;

  localparam int ADDR_W         = 8;
  localparam int DC_BLOCKS      = 8;
  localparam int DC_BLOCK_BYTES = 4;
  localparam int INDEX_W        = $clog2(DC_BLOCKS);
  localparam int OFFSET_W       = $clog2(DC_BLOCK_BYTES);
  localparam int TAG_W          = ADDR_W - INDEX_W - OFFSET_W;
  localparam int BLOCK_W        = DC_BLOCK_BYTES * 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    FETCH     = 2'd2,
    UPDATE    = 2'd3
  } state_e;

endpackage

// File: rtl/dcache_store.sv
// Line storage: valid/dirty/tag/data arrays with a combinational read port,
// a byte-write port for store hits and a whole-line fill port for refills.
module dcache_store
  import dcache_pkg::*;
#(
  parameter  int LINES = DC_BLOCKS,
  parameter  int TG_W  = TAG_W,
  parameter  int BLK_W = BLOCK_W,
  localparam int IDX_W = $clog2(LINES),
  localparam int OFF_W = $clog2(BLK_W / 8)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_valid,
  output logic             rd_dirty,
  output logic [TG_W-1:0]  rd_tag,
  output logic [BLK_W-1:0] rd_data,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [OFF_W-1:0] wr_off,
  input  logic [7:0]       wr_byte,
  input  logic             fill_en,
  input  logic [IDX_W-1:0] fill_idx,
  input  logic [TG_W-1:0]  fill_tag,
  input  logic [BLK_W-1:0] fill_data
);

  logic [LINES-1:0] valid_q;
  logic [LINES-1:0] dirty_q;
  logic [TG_W-1:0]  tag_q  [LINES];
  logic [BLK_W-1:0] data_q [LINES];

  // Data and tags are cleared too so the read port never shows X after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      dirty_q <= '0;
      for (int i = 0; i < LINES; i++) begin
        tag_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else if (fill_en) begin
      valid_q[fill_idx] <= 1'b1;
      dirty_q[fill_idx] <= 1'b0;
      tag_q[fill_idx]   <= fill_tag;
      data_q[fill_idx]  <= fill_data;
    end else if (wr_en) begin
      data_q[wr_idx][{wr_off, 3'b000} +: 8] <= wr_byte;
      dirty_q[wr_idx]                       <= 1'b1;
    end
  end

  // Combinational read of the addressed line.
  always_comb begin
    rd_valid = valid_q[rd_idx];
    rd_dirty = dirty_q[rd_idx];
    rd_tag   = tag_q[rd_idx];
    rd_data  = data_q[rd_idx];
  end

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-back, write-allocate data cache.
// Optional feature macro: DCACHE_STATS_EN adds saturating HIT_COUNT/MISS_COUNT.
module data_cache
  import dcache_pkg::*;
#(
  parameter  int BLOCKS      = DC_BLOCKS,
  parameter  int BLOCK_BYTES = DC_BLOCK_BYTES,
  localparam int IDX_W       = $clog2(BLOCKS),
  localparam int OFF_W       = $clog2(BLOCK_BYTES),
  localparam int TG_W        = ADDR_W - IDX_W - OFF_W,
  localparam int BLK_W       = BLOCK_BYTES * 8,
  localparam int MA_W        = TG_W + IDX_W
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [ADDR_W-1:0] ADDRESS,
  input  logic [7:0]        WRITEDATA,
  input  logic              READ,
  input  logic              WRITE,
  output logic [7:0]        READDATA,
  output logic              BUSYWAIT,
  output logic [MA_W-1:0]   MEM_ADDRESS,
  output logic [BLK_W-1:0]  MEM_WRITEDATA,
  output logic              MEM_READ,
  output logic              MEM_WRITE,
  input  logic [BLK_W-1:0]  MEM_READDATA,
  input  logic              MEM_BUSYWAIT
`ifdef DCACHE_STATS_EN
  ,
  output logic [15:0]       HIT_COUNT,
  output logic [15:0]       MISS_COUNT
`endif
);

  // Request decode
  logic             req;
  logic [TG_W-1:0]  req_tag;
  logic [IDX_W-1:0] req_idx;
  logic [OFF_W-1:0] req_off;

  assign req     = READ | WRITE;
  assign req_tag = ADDRESS[ADDR_W-1 -: TG_W];
  assign req_idx = ADDRESS[OFF_W +: IDX_W];
  assign req_off = ADDRESS[OFF_W-1:0];

  // Addressed line
  logic             ln_valid;
  logic             ln_dirty;
  logic [TG_W-1:0]  ln_tag;
  logic [BLK_W-1:0] ln_data;
  logic             hit;

  // FSM / memory-side registers
  state_e           state_q, state_d;
  logic             first_q;
  logic             mem_done;
  logic             mem_rd_q, mem_rd_d;
  logic             mem_wr_q, mem_wr_d;
  logic [MA_W-1:0]  maddr_q, maddr_d;
  logic [BLK_W-1:0] mwdata_q, mwdata_d;
  logic [BLK_W-1:0] fill_q;
  logic [TG_W-1:0]  miss_tag_q;
  logic [IDX_W-1:0] miss_idx_q;
  logic             wr_hit_en;
  logic             fill_en;

  dcache_store #(
    .LINES (BLOCKS),
    .TG_W  (TG_W),
    .BLK_W (BLK_W)
  ) u_store (
    .clk       (CLK),
    .rst       (RESET),
    .rd_idx    (req_idx),
    .rd_valid  (ln_valid),
    .rd_dirty  (ln_dirty),
    .rd_tag    (ln_tag),
    .rd_data   (ln_data),
    .wr_en     (wr_hit_en),
    .wr_idx    (req_idx),
    .wr_off    (req_off),
    .wr_byte   (WRITEDATA),
    .fill_en   (fill_en),
    .fill_idx  (miss_idx_q),
    .fill_tag  (miss_tag_q),
    .fill_data (fill_q)
  );

  assign hit       = ln_valid && (ln_tag == req_tag);
  assign READDATA  = ln_data[{req_off, 3'b000} +: 8];
  assign BUSYWAIT  = req && (!hit || (state_q != IDLE));
  // READ wins when both strobes are high, so a store only lands if READ is low.
  assign wr_hit_en = (state_q == IDLE) && WRITE && !READ && hit;
  assign fill_en   = (state_q == UPDATE);
  // The entry cycle of a memory state ignores busy (memory may assert it late).
  assign mem_done  = !first_q && !MEM_BUSYWAIT;

  assign MEM_READ      = mem_rd_q;
  assign MEM_WRITE     = mem_wr_q;
  assign MEM_ADDRESS   = maddr_q;
  assign MEM_WRITEDATA = mwdata_q;

  // Next state and next values of the registered memory strobes/address.
  always_comb begin
    state_d  = state_q;
    mem_rd_d = mem_rd_q;
    mem_wr_d = mem_wr_q;
    maddr_d  = maddr_q;
    mwdata_d = mwdata_q;
    case (state_q)
      IDLE: begin
        if (req && !hit) begin
          if (ln_valid && ln_dirty) begin
            state_d  = WRITEBACK;
            mem_wr_d = 1'b1;
            maddr_d  = {ln_tag, req_idx};
            mwdata_d = ln_data;
          end else begin
            state_d  = FETCH;
            mem_rd_d = 1'b1;
            maddr_d  = {req_tag, req_idx};
          end
        end
      end
      WRITEBACK: begin
        if (mem_done) begin
          state_d  = FETCH;
          mem_wr_d = 1'b0;
          mem_rd_d = 1'b1;
          maddr_d  = {miss_tag_q, miss_idx_q};
        end
      end
      FETCH: begin
        if (mem_done) begin
          state_d  = UPDATE;
          mem_rd_d = 1'b0;
        end
      end
      UPDATE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, strobe registers, miss address latch and refill capture.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= IDLE;
      first_q    <= 1'b0;
      mem_rd_q   <= 1'b0;
      mem_wr_q   <= 1'b0;
      maddr_q    <= '0;
      mwdata_q   <= '0;
      fill_q     <= '0;
      miss_tag_q <= '0;
      miss_idx_q <= '0;
    end else begin
      state_q  <= state_d;
      first_q  <= (state_d != state_q);
      mem_rd_q <= mem_rd_d;
      mem_wr_q <= mem_wr_d;
      maddr_q  <= maddr_d;
      mwdata_q <= mwdata_d;
      if (state_q == IDLE && req && !hit) begin
        miss_tag_q <= req_tag;
        miss_idx_q <= req_idx;
      end
      if (state_q == FETCH && mem_done)
        fill_q <= MEM_READDATA;
    end
  end

`ifdef DCACHE_STATS_EN
  logic        hit_evt, miss_evt;
  logic [15:0] hit_cnt_q, miss_cnt_q;

  assign hit_evt    = (state_q == IDLE) && req && hit;
  assign miss_evt   = (state_q == IDLE) && req && !hit;
  assign HIT_COUNT  = hit_cnt_q;
  assign MISS_COUNT = miss_cnt_q;

  // Saturating hit/miss counters.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (hit_evt && hit_cnt_q != 16'hFFFF)
        hit_cnt_q <= hit_cnt_q + 16'd1;
      if (miss_evt && miss_cnt_q != 16'hFFFF)
        miss_cnt_q <= miss_cnt_q + 16'd1;
    end
  end
`else
  // No statistics logic in this build.
`endif

endmodule

// File: tb/tb_data_cache.sv
// Self-checking bench for data_cache: directed scenarios followed by random
// traffic, checked against a byte-level memory image plus a tag directory.
module tb_data_cache;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        READ, WRITE;
  logic [7:0]  ADDRESS, WRITEDATA, READDATA;
  logic        BUSYWAIT;
  logic [5:0]  MEM_ADDRESS;
  logic [31:0] MEM_WRITEDATA, MEM_READDATA;
  logic        MEM_READ, MEM_WRITE, MEM_BUSYWAIT;
`ifdef DCACHE_STATS_EN
  logic [15:0] HIT_COUNT, MISS_COUNT;
`endif

  data_cache dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .ADDRESS       (ADDRESS),
    .WRITEDATA     (WRITEDATA),
    .READ          (READ),
    .WRITE         (WRITE),
    .READDATA      (READDATA),
    .BUSYWAIT      (BUSYWAIT),
    .MEM_ADDRESS   (MEM_ADDRESS),
    .MEM_WRITEDATA (MEM_WRITEDATA),
    .MEM_READ      (MEM_READ),
    .MEM_WRITE     (MEM_WRITE),
    .MEM_READDATA  (MEM_READDATA),
    .MEM_BUSYWAIT  (MEM_BUSYWAIT)
`ifdef DCACHE_STATS_EN
    ,
    .HIT_COUNT     (HIT_COUNT),
    .MISS_COUNT    (MISS_COUNT)
`endif
  );

  always #5 CLK = ~CLK;

  // ---------------- memory model: busy for 'lat' cycles of each strobe run
  function automatic logic [31:0] mem_init(input int i);
    if (i == 0) return 32'hDDCCBBAA;
    return 32'(i * 32'h9E3779B1) ^ 32'h5BD1E995;
  endfunction

  logic [31:0] mem [64];
  logic        mem_loaded = 1'b0;
  int          lat = 1;
  logic [1:0]  kind;
  logic [1:0]  prev_kind = 2'b00;
  int          seen = 0;
  int          eff_seen;

  assign kind         = {MEM_READ, MEM_WRITE};
  assign eff_seen     = (kind == prev_kind) ? seen : 0;
  assign MEM_BUSYWAIT = (kind != 2'b00) && (eff_seen < lat);
  assign MEM_READDATA = mem[MEM_ADDRESS];

  always @(posedge CLK) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 64; i++) mem[i] <= mem_init(i);
      mem_loaded <= 1'b1;
    end else if (MEM_WRITE && !MEM_BUSYWAIT) begin
      mem[MEM_ADDRESS] <= MEM_WRITEDATA;
    end
    prev_kind <= kind;
    seen      <= (kind != 2'b00) ? eff_seen + 1 : 0;
  end

  // ---------------- reference model
  logic [7:0] gold [256];   // architectural byte view
  bit         rv [8];       // which lines hold a block
  bit         rd [8];       // which held blocks are newer than memory
  logic [2:0] rt [8];
  int         exp_hits, exp_miss;

  int          n_vec = 0, n_err = 0;
  logic [7:0]  last_rdata;
  logic [5:0]  last_wbaddr, last_rdaddr;
  logic [31:0] last_wbdata;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reset discards cached dirty data, so the architectural view is memory again.
  task automatic model_reset();
    logic [31:0] w;
    for (int a = 0; a < 256; a++) begin
      w       = mem[a / 4];
      gold[a] = w[8 * (a % 4) +: 8];
    end
    for (int i = 0; i < 8; i++) begin
      rv[i] = 0;
      rd[i] = 0;
      rt[i] = '0;
    end
    exp_hits = 0;
    exp_miss = 0;
  endtask

  // One CPU request, started on a negedge, held until BUSYWAIT drops.
  task automatic run(input bit r, input bit w, input logic [7:0] a,
                     input logic [7:0] d, input int l, input string tag);
    logic [2:0]  idx, tg;
    logic [7:0]  base;
    bit          hit, need_wb, is_wr, to;
    int          f, exp_cyc, cyc, nrd, nwr;
    logic [31:0] exp_wbdata;
    idx     = a[4:2];
    tg      = a[7:5];
    is_wr   = w && !r;
    hit     = rv[idx] && (rt[idx] == tg);
    need_wb = !hit && rv[idx] && rd[idx];
    f       = (l + 1 < 2) ? 2 : l + 1;
    exp_cyc = hit ? 0 : 2 + f + (need_wb ? f : 0);
    base    = {rt[idx], idx, 2'b00};
    exp_wbdata = {gold[base + 3], gold[base + 2], gold[base + 1], gold[base]};

    lat = l;
    READ = r; WRITE = w; ADDRESS = a; WRITEDATA = d;
    cyc = 0; nrd = 0; nwr = 0; to = 0;
    #1;
    while (BUSYWAIT && !to) begin
      if (MEM_READ)  begin nrd++; last_rdaddr = MEM_ADDRESS; end
      if (MEM_WRITE) begin nwr++; last_wbaddr = MEM_ADDRESS; last_wbdata = MEM_WRITEDATA; end
      cyc++;
      if (cyc > 300) to = 1;
      @(negedge CLK); #1;
    end
    if (MEM_READ)  nrd++;
    if (MEM_WRITE) nwr++;
    last_rdata = READDATA;
    @(negedge CLK);
    READ = 0; WRITE = 0;

    chk({tag, " timeout"}, 32'(to), 32'd0);
    chk({tag, " busy_cycles"}, 32'(cyc), 32'(exp_cyc));
    chk({tag, " mem_read_cycles"}, 32'(nrd), hit ? 32'd0 : 32'(f));
    chk({tag, " mem_write_cycles"}, 32'(nwr), need_wb ? 32'(f) : 32'd0);
    if (!hit) chk({tag, " fetch_addr"}, 32'(last_rdaddr), 32'({tg, idx}));
    if (need_wb) begin
      chk({tag, " wb_addr"}, 32'(last_wbaddr), 32'({rt[idx], idx}));
      chk({tag, " wb_data"}, last_wbdata, exp_wbdata);
    end
    if (r) chk({tag, " readdata"}, 32'(last_rdata), 32'(gold[a]));

    if (!hit) begin
      exp_miss++;
      rv[idx] = 1;
      rt[idx] = tg;
      rd[idx] = 0;
    end
    exp_hits++;
    if (is_wr) begin
      gold[a] = d;
      rd[idx] = 1;
    end
  endtask

  task automatic chk_stats(input string tag);
`ifdef DCACHE_STATS_EN
    chk({tag, " hit_count"}, 32'(HIT_COUNT), 32'(exp_hits));
    chk({tag, " miss_count"}, 32'(MISS_COUNT), 32'(exp_miss));
`else
    n_vec += 0;
    if (tag.len() == 0) n_vec += 0;
`endif
  endtask

  initial begin
    int k, cnt;
    RESET = 1; READ = 0; WRITE = 0; ADDRESS = '0; WRITEDATA = '0;
    repeat (3) @(negedge CLK);
    #1;
    chk("reset mem_read", 32'(MEM_READ), 32'd0);
    chk("reset mem_write", 32'(MEM_WRITE), 32'd0);
    chk("reset mem_address", 32'(MEM_ADDRESS), 32'd0);
    chk("reset busy_idle", 32'(BUSYWAIT), 32'd0);
    chk("reset readdata_known", 32'($isunknown(READDATA)), 32'd0);
    READ = 1; #1;
    chk("reset busy_req", 32'(BUSYWAIT), 32'd1);
    READ = 0;
    @(negedge CLK);
    RESET = 0;
    model_reset();
    chk_stats("reset");

    // clean miss, 5 busy memory cycles
    run(1, 0, 8'h00, 8'h00, 5, "tp1");
    chk("tp1 byte0", 32'(last_rdata), 32'h000000AA);
    // hit in the same line
    run(1, 0, 8'h03, 8'h00, 5, "tp2");
    chk("tp2 byte3", 32'(last_rdata), 32'h000000DD);
    // write hit then conflicting read forces write-back
    run(0, 1, 8'h01, 8'h5A, 2, "tp3w");
    run(1, 0, 8'h21, 8'h00, 2, "tp3r");
    chk("tp3 wb_addr", 32'(last_wbaddr), 32'h00);
    chk("tp3 wb_data", last_wbdata, 32'hDDCC5AAA);
    chk("tp3 fetch_addr", 32'(last_rdaddr), 32'h08);
    // write miss allocates, line becomes dirty
    run(0, 1, 8'h45, 8'h77, 1, "tp4w");
    run(1, 0, 8'h45, 8'h00, 1, "tp4r");
    chk("tp4 readback", 32'(last_rdata), 32'h77);
    run(1, 0, 8'hC5, 8'h00, 3, "tp4c");
    chk("tp4 wb_addr", 32'(last_wbaddr), 32'h11);
    // read/write together behaves as read
    run(1, 1, 8'hC6, 8'hEE, 1, "both");

    // reset in the 3rd FETCH cycle
    lat = 5;
    READ = 1; ADDRESS = 8'h1C;
    k = 0; cnt = 0;
    #1;
    while (cnt < 3 && k < 50) begin
      if (MEM_READ) cnt++;
      if (cnt < 3) begin @(negedge CLK); #1; k++; end
    end
    chk("abort reached_fetch3", 32'(cnt), 32'd3);
    RESET = 1;
    @(negedge CLK); #1;
    chk("abort mem_read", 32'(MEM_READ), 32'd0);
    chk("abort mem_address", 32'(MEM_ADDRESS), 32'd0);
    chk("abort busy", 32'(BUSYWAIT), 32'd1);
    RESET = 0; READ = 0;
    model_reset();
    chk_stats("abort");
    @(negedge CLK);
    run(1, 0, 8'h1C, 8'h00, 3, "reread");
    run(1, 0, 8'h1C, 8'h00, 3, "rehit");
    run(1, 0, 8'h3C, 8'h00, 2, "stat_miss");
`ifdef DCACHE_STATS_EN
    chk("stats hit3", 32'(HIT_COUNT), 32'd3);
    chk("stats miss2", 32'(MISS_COUNT), 32'd2);
`endif
    RESET = 1;
    @(negedge CLK);
    RESET = 0;
    model_reset();
    #1;
    chk_stats("stats_clear");
    @(negedge CLK);

    // random traffic over a few indices to force conflicts
    for (int n = 0; n < 200; n++) begin
      logic [7:0] a;
      int op;
      a  = {3'($urandom_range(0, 7)), 3'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
      op = $urandom_range(0, 3);
      run(op != 2, op >= 2, a, 8'($urandom), $urandom_range(0, 4), $sformatf("rnd%0d", n));
    end
    #1;
    chk_stats("final");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/data_cache.md
# data_cache

Direct-mapped, write-back, write-allocate data cache between the CPU's load/store datapath and the 32-bit-block data memory. Its `READDATA` output feeds the register-file input mux's `DataMem_READDATA` leg. `BUSYWAIT` stalls the CPU (PC update and register write) on a miss. The cache holds 8 blocks of 4 bytes each and serves an 8-bit byte address.

## Interface
- `BLOCKS`, 8: number of cache lines (index width = log2).
- `BLOCK_BYTES`, 4: bytes per line (offset width = log2). The memory word is `BLOCK_BYTES`×8 bits.
- `CLK` input 1: clock; all state updates on the rising edge.
- `RESET` input 1: synchronous, active-high.
- `ADDRESS` input 8: byte address, split as tag[7:5], index[4:2], offset[1:0].
- `WRITEDATA` input 8: store data.
- `READ`, `WRITE` input 1 each: CPU load/store request, held until `BUSYWAIT` is low.
- `READDATA` output 8: load data.
- `BUSYWAIT` output 1: CPU stall.
- `MEM_ADDRESS` output 6: block address {tag, index}.
- `MEM_WRITEDATA` output 32: block being written back.
- `MEM_READ`, `MEM_WRITE` output 1 each: memory strobes.
- `MEM_READDATA` input 32: fetched block.
- `MEM_BUSYWAIT` input 1: memory busy.
- `HIT_COUNT`, `MISS_COUNT` output 16 each: present only with `DCACHE_STATS_EN`.

## Operation
- Per line state: `valid`, `dirty`, 3-bit tag, 32-bit data. Byte n of the block is data[8n+7:8n].
- Hit means `valid` is set and the stored tag equals `ADDRESS`[7:5]. Hit and `READDATA` are combinational from the array and address.
- If `READ` and `WRITE` are both high, the request is treated as `READ` and the store is ignored.
- FSM states and transitions:
  - `IDLE`, hit:
    - Read hit: `READDATA` is the addressed byte, `BUSYWAIT` is 0.
    - Write hit: the byte is written and `dirty` is set on this edge; `BUSYWAIT` is 0.
  - `IDLE`, miss on a valid line with `dirty` set: go to `WRITEBACK`.
  - `IDLE`, any other miss: go to `FETCH`.
  - `WRITEBACK`: drives `MEM_WRITE`=1, `MEM_ADDRESS`={old tag, index}, `MEM_WRITEDATA`=line data. Goes to `FETCH` on the first edge after the entry cycle where `MEM_BUSYWAIT`=0.
  - `FETCH`: drives `MEM_READ`=1, `MEM_ADDRESS`={new tag, index}. Goes to `UPDATE` on the same exit rule as `WRITEBACK`. `MEM_READDATA` is captured on that edge.
  - `UPDATE`: for one cycle, writes the captured block, new tag, `valid`=1, `dirty`=0, then returns to `IDLE`. The still-held request then hits.
- `BUSYWAIT` = (`READ`|`WRITE`) & (miss | state≠`IDLE`).
- `READDATA` is undefined-stable (last array value) when there is no request. It must not glitch to X after reset.
- Misses on different indices are independent. There is no replacement choice (direct-mapped).

## Timing
- Reset values:
  - State `IDLE`.
  - All `valid` and `dirty` cleared (data and tags need not be cleared).
  - `MEM_READ`=`MEM_WRITE`=0 and `MEM_ADDRESS`=0 from the cycle after `RESET` is sampled.
  - `BUSYWAIT` follows its equation, i.e. 1 if a request is present, since everything misses.
  - Counters 0.
- Hit latency is 0 cycles: the request completes on the edge where it is presented.
- Clean miss: 1 (`IDLE`) + F (`FETCH`, F ≥ 1 = memory latency) + 1 (`UPDATE`) + 1 (`IDLE` hit) cycles of request.
- Dirty miss adds W ≥ 1 `WRITEBACK` cycles.
- The first cycle of `WRITEBACK` and of `FETCH` ignores `MEM_BUSYWAIT`, covering a memory that raises busy one cycle late.
- Memory strobes are registered state decodes: glitch-free, constant for the whole state.
- `RESET` mid-miss aborts: strobes drop next cycle and the line is left invalid. A partial write-back is lost; this is accepted.

## Configuration
- `DCACHE_STATS_EN`: adds `HIT_COUNT` and `MISS_COUNT`.
  - `HIT_COUNT` increments per hit completed in `IDLE`.
  - `MISS_COUNT` increments per `IDLE`→`WRITEBACK`/`FETCH` transition.
  - Both saturate at 16'hFFFF and clear on `RESET`.
- Without the macro the ports and logic are absent. Behaviour is otherwise identical.

## Structure
- Package `dcache_pkg`: state enum (`IDLE`, `WRITEBACK`, `FETCH`, `UPDATE`), the `TAG_W`/`INDEX_W`/`OFFSET_W` constants, and the memory block width.
- Sub-module `dcache_store` holds the valid/dirty/tag/data arrays. It has:
  - a combinational read port (index → line);
  - a byte-write port used by write hits;
  - a whole-line fill port used by `UPDATE`;
  - synchronous clear of `valid`/`dirty` on `RESET`.
- `data_cache` holds the FSM, hit compare, byte select, memory interface, and the optional counters.

## Test plan
- After reset, `READ` at 8'h00 with the memory model returning 32'hDDCCBBAA after 5 busy cycles: `MEM_READ` high for 6 cycles, `BUSYWAIT` high through `UPDATE`, then `READDATA`=8'hAA; `MEM_WRITE` never asserted.
- `READ` at 8'h03 next: hit, `BUSYWAIT`=0 in the same cycle, `READDATA`=8'hDD, no memory strobe.
- `WRITE` 8'h5A at 8'h01 (hit), then `READ` at 8'h21 (same index, tag 1): `MEM_WRITE` with `MEM_ADDRESS`=6'h00 and `MEM_WRITEDATA`=32'hDDCC5AAA, followed by `MEM_READ` with `MEM_ADDRESS`=6'h08.
- `WRITE` 8'h77 at 8'h45 (miss, clean): fetch, `UPDATE`, then the byte is written; a subsequent `READ` at 8'h45 returns 8'h77 and the line is dirty (a later conflict triggers write-back).
- Assert `RESET` in the 3rd `FETCH` cycle: `MEM_READ`=0 next cycle, state `IDLE`, and a re-read of the same address misses again.
- With `DCACHE_STATS_EN`: 3 hits and 2 misses give `HIT_COUNT`=3 and `MISS_COUNT`=2; `RESET` returns both to 0.
